// File: rtl/dds_pkg.sv
// DDS phase generator shared types and constants.
// Used by the accumulator top, its interface and the quarter-wave map.
package dds_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DDS_ACC_W  = 32;
  localparam int DDS_ADDR_W = 12;

  localparam logic [1:0] QUAD_RISE_POS = 2'd0;
  localparam logic [1:0] QUAD_FALL_POS = 2'd1;
  localparam logic [1:0] QUAD_RISE_NEG = 2'd2;
  localparam logic [1:0] QUAD_FALL_NEG = 2'd3;

endpackage

// File: rtl/dds_phase_gen_if.sv
// Control/ROM-side bundle of the DDS phase generator.
// master = controller + ROM consumer, slave = the generator.
interface dds_phase_gen_if
  import dds_pkg::*;
#(
  parameter int ACC_W  = DDS_ACC_W,
  parameter int ADDR_W = DDS_ADDR_W
);

  logic              start;
  logic              stop;
  logic [ACC_W-1:0]  ftw_in;
  logic              ftw_valid;
  logic              ftw_ready;
  logic [ADDR_W-1:0] phase_ofs;
  logic [ADDR_W-1:0] rom_address;
  logic              sign;
  logic              addr_valid;
  logic              wrap;
  logic              busy;

  modport master (
    output start, stop, ftw_in,
    output ftw_valid, phase_ofs,
    input  ftw_ready, rom_address,
    input  sign, addr_valid,
    input  wrap, busy
  );

  modport slave (
    input  start, stop, ftw_in,
    input  ftw_valid, phase_ofs,
    output ftw_ready, rom_address,
    output sign, addr_valid,
    output wrap, busy
  );

endinterface

// File: rtl/dds_quarter_map.sv
// Folds a full-period phase onto a quarter-wave ROM.
// Odd quadrants run the index backwards; the upper half sets sign.
module dds_quarter_map
  import dds_pkg::*;
#(
  parameter int ADDR_W = DDS_ADDR_W
) (
  input  logic [ADDR_W-1:0] phase,
  output logic [ADDR_W-1:0] addr,
  output logic              sign
);

  logic [1:0]        quad;
  logic [ADDR_W-3:0] idx;

  assign quad = phase[ADDR_W-1 -: 2];
  assign idx  = phase[ADDR_W-3:0];

  always_comb begin
    addr = '0;
    sign = 1'b0;
    unique case (quad)
      QUAD_RISE_POS: begin
        addr = {2'b00, idx};
        sign = 1'b0;
      end
      QUAD_FALL_POS: begin
        addr = {2'b00, ~idx};
        sign = 1'b0;
      end
      QUAD_RISE_NEG: begin
        addr = {2'b00, idx};
        sign = 1'b1;
      end
      QUAD_FALL_NEG: begin
        addr = {2'b00, ~idx};
        sign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dds_phase_gen.sv
// DDS phase accumulator with FTW handshake and
// registered sine-ROM address generation.
module dds_phase_gen
  import dds_pkg::*;
#(
  parameter int ACC_W          = DDS_ACC_W,
  parameter int ADDR_W         = DDS_ADDR_W,
  parameter bit QUARTER        = 1'b0,
  parameter bit UPDATE_ON_WRAP = 1'b0
) (
  input logic           clk,
  input logic           reset,
  dds_phase_gen_if.slave bus
);

  state_t            state_q;
  state_t            state_d;
  logic [ACC_W-1:0]  acc_q;
  logic              carry_q;
  logic [ACC_W-1:0]  ftw_act_q;
  logic [ACC_W-1:0]  pend_q;
  logic              pend_vld_q;
  logic [ACC_W:0]    sum;
  logic              run;
  logic              fire;
  logic [ADDR_W-1:0] phase;
  logic [ADDR_W-1:0] map_addr;
  logic              map_sign;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              sign_q;
  logic              valid_q;
  logic              wrap_q;

  assign run  = (state_q == RUN);
  assign fire = bus.ftw_valid & ~pend_vld_q;
  assign sum  = {1'b0, acc_q} + {1'b0, ftw_act_q};

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      bus.stop:              state_d = IDLE;
      bus.start & ~bus.stop: state_d = RUN;
      default:               state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (run && !bus.stop) begin
      {carry_q, acc_q} <= sum;
    end else begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end
  end

  // Deferred words wait in pend_q until the accumulator wraps or stops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ftw_act_q  <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else if (!run || !UPDATE_ON_WRAP) begin
      if (fire) ftw_act_q <= bus.ftw_in;
    end else if (bus.stop) begin
      if (fire) begin
        ftw_act_q <= bus.ftw_in;
      end else if (pend_vld_q) begin
        ftw_act_q <= pend_q;
      end
      pend_vld_q <= 1'b0;
    end else begin
      if (sum[ACC_W] && pend_vld_q) begin
        ftw_act_q  <= pend_q;
        pend_vld_q <= 1'b0;
      end
      if (fire) begin
        pend_q     <= bus.ftw_in;
        pend_vld_q <= 1'b1;
      end
    end
  end

  assign phase = acc_q[ACC_W-1 -: ADDR_W]
               + bus.phase_ofs;

  if (QUARTER) begin : g_quarter
    dds_quarter_map #(
      .ADDR_W (ADDR_W)
    ) u_map (
      .phase (phase),
      .addr  (map_addr),
      .sign  (map_sign)
    );
  end else begin : g_linear
    assign map_addr = phase;
    assign map_sign = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_addr_q <= '0;
      sign_q     <= 1'b0;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      valid_q <= run;
      wrap_q  <= carry_q;
      if (run) begin
        rom_addr_q <= map_addr;
        sign_q     <= map_sign;
      end
    end
  end

  assign bus.ftw_ready   = ~pend_vld_q;
  assign bus.rom_address = rom_addr_q;
  assign bus.sign        = sign_q;
  assign bus.addr_valid  = valid_q;
  assign bus.wrap        = wrap_q;
  assign bus.busy        = run;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Bench for dds_phase_gen: linear, quarter-wave and
// update-on-wrap instances driven by shared stimulus.
module tb_dds_phase_gen;

  localparam int AW = 16;
  localparam int DW = 12;
  localparam int unsigned ACC_MOD = 65536;
  localparam int unsigned SHIFT   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic ftw_valid = 1'b0;
  logic [AW-1:0] ftw_in = '0;
  logic [DW-1:0] ofs = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dds_phase_gen_if #(.ACC_W(AW), .ADDR_W(DW)) if0 ();
  dds_phase_gen_if #(.ACC_W(AW), .ADDR_W(DW)) if1 ();
  dds_phase_gen_if #(.ACC_W(AW), .ADDR_W(DW)) if2 ();

  assign if0.start = start;
  assign if1.start = start;
  assign if2.start = start;
  assign if0.stop = stop;
  assign if1.stop = stop;
  assign if2.stop = stop;
  assign if0.ftw_in = ftw_in;
  assign if1.ftw_in = ftw_in;
  assign if2.ftw_in = ftw_in;
  assign if0.ftw_valid = ftw_valid;
  assign if1.ftw_valid = ftw_valid;
  assign if2.ftw_valid = ftw_valid;
  assign if0.phase_ofs = ofs;
  assign if1.phase_ofs = ofs;
  assign if2.phase_ofs = ofs;

  dds_phase_gen #(
    .ACC_W(AW), .ADDR_W(DW),
    .QUARTER(1'b0), .UPDATE_ON_WRAP(1'b0)
  ) u_lin (
    .clk(clk), .reset(rst_n), .bus(if0.slave)
  );

  dds_phase_gen #(
    .ACC_W(AW), .ADDR_W(DW),
    .QUARTER(1'b1), .UPDATE_ON_WRAP(1'b0)
  ) u_qtr (
    .clk(clk), .reset(rst_n), .bus(if1.slave)
  );

  dds_phase_gen #(
    .ACC_W(AW), .ADDR_W(DW),
    .QUARTER(1'b0), .UPDATE_ON_WRAP(1'b1)
  ) u_uow (
    .clk(clk), .reset(rst_n), .bus(if2.slave)
  );

  // Reference model state, one slot per instance.
  bit          m_qtr[3] = '{1'b0, 1'b1, 1'b0};
  bit          m_uow[3] = '{1'b0, 1'b0, 1'b1};
  bit          m_run[3];
  int unsigned m_acc[3];
  bit          m_carry[3];
  int unsigned m_ftw[3];
  bit          m_pv[3];
  int unsigned m_pw[3];
  int unsigned m_addr[3];
  bit          m_sign[3];
  bit          m_valid[3];
  bit          m_wrap[3];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      m_run[m] = 0; m_acc[m] = 0; m_carry[m] = 0;
      m_ftw[m] = 0; m_pv[m] = 0; m_pw[m] = 0;
      m_addr[m] = 0; m_sign[m] = 0;
      m_valid[m] = 0; m_wrap[m] = 0;
    end
  endtask

  // Phase index = top 12 bits of acc plus offset, mod 4096.
  task automatic rom_map(int unsigned acc, int unsigned po,
                         bit qtr, output int unsigned a,
                         output bit s);
    int unsigned p, quad, idx;
    p = ((acc / SHIFT) + po) % 4096;
    if (!qtr) begin
      a = p; s = 0;
    end else begin
      quad = p / 1024;
      idx  = p % 1024;
      a = (quad % 2 == 1) ? 1023 - idx : idx;
      s = (quad >= 2);
    end
  endtask

  task automatic model_step(int m);
    bit fire, c;
    int unsigned total;
    fire = ftw_valid && !m_pv[m];
    m_valid[m] = m_run[m];
    m_wrap[m]  = m_run[m] && m_carry[m];
    if (m_run[m])
      rom_map(m_acc[m], ofs, m_qtr[m], m_addr[m], m_sign[m]);
    c = 0;
    if (m_run[m] && !stop) begin
      total = m_acc[m] + m_ftw[m];
      c = (total >= ACC_MOD);
      m_acc[m] = total % ACC_MOD;
    end else begin
      m_acc[m] = 0;
    end
    m_carry[m] = c;
    if (!m_run[m] || !m_uow[m]) begin
      if (fire) m_ftw[m] = ftw_in;
    end else if (stop) begin
      if (fire) m_ftw[m] = ftw_in;
      else if (m_pv[m]) m_ftw[m] = m_pw[m];
      m_pv[m] = 0;
    end else begin
      if (c && m_pv[m]) begin
        m_ftw[m] = m_pw[m];
        m_pv[m] = 0;
      end
      if (fire) begin
        m_pv[m] = 1;
        m_pw[m] = ftw_in;
      end
    end
    if (stop) m_run[m] = 0;
    else if (start) m_run[m] = 1;
  endtask

  task automatic cmp_inst(int m, logic [DW-1:0] a, logic s,
                          logic v, logic w, logic b,
                          logic r);
    chk($sformatf("m%0d_addr", m), a, m_addr[m]);
    chk($sformatf("m%0d_sign", m), s, m_sign[m]);
    chk($sformatf("m%0d_valid", m), v, m_valid[m]);
    chk($sformatf("m%0d_wrap", m), w, m_wrap[m]);
    chk($sformatf("m%0d_busy", m), b, m_run[m]);
    chk($sformatf("m%0d_ready", m), r, !m_pv[m]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n)
      for (int m = 0; m < 3; m++) model_step(m);
    @(negedge clk);
    cmp_inst(0, if0.rom_address, if0.sign, if0.addr_valid,
             if0.wrap, if0.busy, if0.ftw_ready);
    cmp_inst(1, if1.rom_address, if1.sign, if1.addr_valid,
             if1.wrap, if1.busy, if1.ftw_ready);
    cmp_inst(2, if2.rom_address, if2.sign, if2.addr_valid,
             if2.wrap, if2.busy, if2.ftw_ready);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic launch(logic [AW-1:0] f, logic [DW-1:0] o);
    ftw_in = f; ofs = o;
    ftw_valid = 1'b1; start = 1'b1;
    tick();
    ftw_valid = 1'b0; start = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] ftw;
    logic [DW-1:0] ofs;
    int            n;
    logic [DW-1:0] addr;
    logic          wrap;
    logic [DW-1:0] qaddr;
    logic          qsign;
  } vec_t;

  vec_t vecs[11];

  initial begin
    bit found;
    logic [DW-1:0] hold;
    vecs[0]  = '{16'h1000, 12'h000,  1, 12'h100, 1'b0, 12'h100, 1'b0};
    vecs[1]  = '{16'h1000, 12'h000,  5, 12'h500, 1'b0, 12'h2FF, 1'b0};
    vecs[2]  = '{16'h1000, 12'h000, 15, 12'hF00, 1'b0, 12'h0FF, 1'b1};
    vecs[3]  = '{16'h1000, 12'h000, 16, 12'h000, 1'b1, 12'h000, 1'b0};
    vecs[4]  = '{16'h1000, 12'h800,  1, 12'h900, 1'b0, 12'h100, 1'b1};
    vecs[5]  = '{16'h1000, 12'h800,  9, 12'h100, 1'b0, 12'h100, 1'b0};
    vecs[6]  = '{16'h1000, 12'h800, 16, 12'h800, 1'b1, 12'h000, 1'b1};
    vecs[7]  = '{16'h0100, 12'h000, 63, 12'h3F0, 1'b0, 12'h3F0, 1'b0};
    vecs[8]  = '{16'h0100, 12'h000, 64, 12'h400, 1'b0, 12'h3FF, 1'b0};
    vecs[9]  = '{16'hFFFF, 12'h000,  1, 12'hFFF, 1'b0, 12'h000, 1'b1};
    vecs[10] = '{16'hFFFF, 12'h000,  2, 12'hFFF, 1'b1, 12'h000, 1'b1};

    model_reset();
    @(negedge clk);
    chk("rst_ready", if0.ftw_ready, 1'b1);
    chk("rst_addr", if0.rom_address, '0);
    do_reset();

    // Sample n is the n-th valid address after START.
    foreach (vecs[i]) begin
      do_reset();
      launch(vecs[i].ftw, vecs[i].ofs);
      repeat (vecs[i].n + 1) tick();
      chk($sformatf("v%0d_valid", i), if0.addr_valid, 1'b1);
      chk($sformatf("v%0d_addr", i), if0.rom_address,
          vecs[i].addr);
      chk($sformatf("v%0d_wrap", i), if0.wrap, vecs[i].wrap);
      chk($sformatf("v%0d_qaddr", i), if1.rom_address,
          vecs[i].qaddr);
      chk($sformatf("v%0d_qsign", i), if1.sign, vecs[i].qsign);
    end

    // Async reset mid-run with a pending word.
    do_reset();
    launch(16'h1000, 12'h000);
    repeat (3) tick();
    ftw_in = 16'h3000; ftw_valid = 1'b1;
    tick();
    ftw_valid = 1'b0;
    chk("ar_pending", if2.ftw_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_addr", if0.rom_address, '0);
    chk("ar_valid", if0.addr_valid, 1'b0);
    chk("ar_busy", if0.busy, 1'b0);
    chk("ar_ready", if2.ftw_ready, 1'b1);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_idle", if2.busy, 1'b0);

    // Update-on-wrap: new step only after the wrap.
    do_reset();
    launch(16'h1000, 12'h000);
    repeat (5) tick();
    ftw_in = 16'h2000; ftw_valid = 1'b1;
    tick();
    ftw_valid = 1'b0;
    chk("uow_busy_wait", if2.ftw_ready, 1'b0);
    chk("uow_lin_ready", if0.ftw_ready, 1'b1);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (if2.wrap) found = 1;
    end
    chk("uow_wrap_seen", found, 1'b1);
    chk("uow_ready_back", if2.ftw_ready, 1'b1);
    chk("uow_wrap_addr", if2.rom_address, 12'h000);
    tick();
    chk("uow_step1", if2.rom_address, 12'h200);
    tick();
    chk("uow_step2", if2.rom_address, 12'h400);

    // START with STOP, STOP in RUN, zero FTW.
    do_reset();
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_idle", if0.busy, 1'b0);
    launch(16'h1000, 12'h000);
    repeat (3) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", if0.busy, 1'b0);
    chk("stop_valid_hi", if0.addr_valid, 1'b1);
    tick();
    chk("stop_valid_lo", if0.addr_valid, 1'b0);
    hold = if0.rom_address;
    tick();
    chk("idle_hold", if0.rom_address, hold);
    launch(16'h0000, 12'h123);
    found = 0;
    repeat (40) begin
      tick();
      if (if0.wrap) found = 1;
    end
    chk("zero_nowrap", found, 1'b0);
    chk("zero_valid", if0.addr_valid, 1'b1);
    chk("zero_addr", if0.rom_address, 12'h123);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Random stimulus against the model.
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 15) == 0);
      stop  = ($urandom_range(0, 23) == 0);
      ftw_valid = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0: ftw_in = 16'h1000;
        1: ftw_in = 16'h0100;
        2: ftw_in = 16'hFFFF;
        3: ftw_in = 16'($urandom);
        default: ftw_in = 16'h0000;
      endcase
      if ($urandom_range(0, 31) == 0) ofs = 12'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
